seller_arbiter: RTL and testbench

- Shares one ticket-seller core among NWIN independent ticket windows.
- Arbitrates window purchase requests round-robin and validates the request fields.
- Issues a start to the core, then waits for completion with a watchdog timeout.
- Routes the change/sheet result back to the granted window; sits between the window front-ends and the single seller core.

---
 rtl/seller_arbiter.sv | 224 ++++++++++++++++++++++
 tb/tb_seller_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seller_arbiter.sv
// ---------------------------------------------------------------------------
// seller_arbiter
//
// Shares a single ticket-seller core among NWIN ticket windows. Requests are
// granted round-robin, their fields are validated, a start is issued to the
// core, and a watchdog aborts the core if it does not complete in time. The
// core's change/sheet result is routed back to the window that owns the grant.
//
// Ports
//   clk, reset          : rising-edge clock, asynchronous active-low reset
//   win_req             : per-window level request, held until done/abort
//   win_station1/2      : per-window stations, 4 bits per window
//   win_sheet           : per-window sheet count, 3 bits per window
//   win_gnt             : one-hot grant to the window owning the core
//   win_done/win_abort  : one-cycle completion / reject pulse to that window
//   out_change/sheet    : result, valid while a win_done bit is high
//   core_start          : one-cycle start to the core
//   core_station1/2,
//   core_sheet          : fields latched at accept, stable through WAIT
//   core_abort          : one-cycle cancel to the core on timeout
//   core_done           : core completion pulse
//   core_change,
//   core_sheet_out      : core result, sampled with core_done
// ---------------------------------------------------------------------------
module seller_arbiter #(
   parameter int NWIN     = 4,
   parameter int TIMEOUT  = 64,
   parameter int MAXSHEET = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NWIN-1:0]   win_req,
   input  logic [4*NWIN-1:0] win_station1,
   input  logic [4*NWIN-1:0] win_station2,
   input  logic [3*NWIN-1:0] win_sheet,
   output logic [NWIN-1:0]   win_gnt,
   output logic [NWIN-1:0]   win_done,
   output logic [NWIN-1:0]   win_abort,
   output logic [6:0]        out_change,
   output logic [2:0]        out_sheet,
   output logic              core_start,
   output logic [3:0]        core_station1,
   output logic [3:0]        core_station2,
   output logic [2:0]        core_sheet,
   output logic              core_abort,
   input  logic              core_done,
   input  logic [6:0]        core_change,
   input  logic [2:0]        core_sheet_out
);

   localparam int PW = (NWIN > 1) ? $clog2(NWIN) : 1;
   localparam int TW = $clog2(TIMEOUT);
   localparam logic [TW-1:0] TIMER_LAST  = TW'(TIMEOUT - 1);
   localparam logic [PW-1:0] LAST_WIN    = PW'(NWIN - 1);
   localparam logic [3:0]    SHEET_LIMIT = (MAXSHEET > 15) ? 4'd15 : 4'(MAXSHEET);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_ISSUE,
      S_WAIT,
      S_RETIRE,
      S_REJECT
   } state_t;

   state_t          state_q,         state_d;
   logic [PW-1:0]   ptr_q,           ptr_d;
   logic [PW-1:0]   idx_q,           idx_d;
   logic [TW-1:0]   timer_q,         timer_d;
   logic [NWIN-1:0] win_gnt_q,       win_gnt_d;
   logic [NWIN-1:0] win_done_q,      win_done_d;
   logic [NWIN-1:0] win_abort_q,     win_abort_d;
   logic [6:0]      out_change_q,    out_change_d;
   logic [2:0]      out_sheet_q,     out_sheet_d;
   logic            core_start_q,    core_start_d;
   logic            core_abort_q,    core_abort_d;
   logic [3:0]      core_station1_q, core_station1_d;
   logic [3:0]      core_station2_q, core_station2_d;
   logic [2:0]      core_sheet_q,    core_sheet_d;

   logic            pick_found;
   logic [PW-1:0]   pick_idx;
   logic [PW-1:0]   cand;
   logic            req_invalid;
   logic [PW-1:0]   ptr_next;

   // Round-robin search: first requester at or above ptr, wrapping around.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int k = 0; k < NWIN; k++) begin
         cand = PW'((int'(ptr_q) + k) % NWIN);
         if (!pick_found && win_req[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   // Validation works on the latched copy so later window changes are ignored.
   assign req_invalid = (core_station1_q == 4'd0) ||
                        (core_station2_q == 4'd0) ||
                        (core_station2_q < core_station1_q) ||
                        (core_sheet_q == 3'd0) ||
                        ({1'b0, core_sheet_q} > SHEET_LIMIT);

   // The window just served goes to the back of the search order.
   assign ptr_next = (idx_q == LAST_WIN) ? '0 : idx_q + 1'b1;

   always_comb begin
      state_d         = state_q;
      ptr_d           = ptr_q;
      idx_d           = idx_q;
      timer_d         = timer_q;
      win_gnt_d       = win_gnt_q;
      core_station1_d = core_station1_q;
      core_station2_d = core_station2_q;
      core_sheet_d    = core_sheet_q;
      win_done_d      = '0;
      win_abort_d     = '0;
      out_change_d    = '0;
      out_sheet_d     = '0;
      core_start_d    = 1'b0;
      core_abort_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (pick_found) begin
               state_d             = S_CHECK;
               idx_d               = pick_idx;
               win_gnt_d           = '0;
               win_gnt_d[pick_idx] = 1'b1;
               core_station1_d     = win_station1[4*pick_idx +: 4];
               core_station2_d     = win_station2[4*pick_idx +: 4];
               core_sheet_d        = win_sheet[3*pick_idx +: 3];
            end
         end
         S_CHECK: begin
            if (req_invalid) begin
               state_d     = S_REJECT;
               win_abort_d = win_gnt_q;
            end else begin
               state_d      = S_ISSUE;
               core_start_d = 1'b1;
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT;
            timer_d = '0;
         end
         S_WAIT: begin
            // A completion on the final watchdog cycle still counts as done.
            if (core_done) begin
               state_d      = S_RETIRE;
               win_done_d   = win_gnt_q;
               out_change_d = core_change;
               out_sheet_d  = core_sheet_out;
            end else if (timer_q == TIMER_LAST) begin
               state_d      = S_REJECT;
               core_abort_d = 1'b1;
               win_abort_d  = win_gnt_q;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_RETIRE, S_REJECT: begin
            state_d   = S_IDLE;
            win_gnt_d = '0;
            ptr_d     = ptr_next;
         end
         default: begin
            state_d   = S_IDLE;
            win_gnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q         <= S_IDLE;
         ptr_q           <= '0;
         idx_q           <= '0;
         timer_q         <= '0;
         win_gnt_q       <= '0;
         win_done_q      <= '0;
         win_abort_q     <= '0;
         out_change_q    <= '0;
         out_sheet_q     <= '0;
         core_start_q    <= 1'b0;
         core_abort_q    <= 1'b0;
         core_station1_q <= '0;
         core_station2_q <= '0;
         core_sheet_q    <= '0;
      end else begin
         state_q         <= state_d;
         ptr_q           <= ptr_d;
         idx_q           <= idx_d;
         timer_q         <= timer_d;
         win_gnt_q       <= win_gnt_d;
         win_done_q      <= win_done_d;
         win_abort_q     <= win_abort_d;
         out_change_q    <= out_change_d;
         out_sheet_q     <= out_sheet_d;
         core_start_q    <= core_start_d;
         core_abort_q    <= core_abort_d;
         core_station1_q <= core_station1_d;
         core_station2_q <= core_station2_d;
         core_sheet_q    <= core_sheet_d;
      end
   end

   assign win_gnt       = win_gnt_q;
   assign win_done      = win_done_q;
   assign win_abort     = win_abort_q;
   assign out_change    = out_change_q;
   assign out_sheet     = out_sheet_q;
   assign core_start    = core_start_q;
   assign core_abort    = core_abort_q;
   assign core_station1 = core_station1_q;
   assign core_station2 = core_station2_q;
   assign core_sheet    = core_sheet_q;

endmodule

// File: tb/tb_seller_arbiter.sv
// ---------------------------------------------------------------------------
// tb_seller_arbiter
//
// Directed bench for seller_arbiter with NWIN=4, TIMEOUT=8, MAXSHEET=5.
// Each request pushes its expected window response, its expected core start
// fields and the behaviour of the core stub into queues; monitors pop and
// compare whenever the arbiter presents a start or a done/abort pulse.
// ---------------------------------------------------------------------------
module tb_seller_arbiter;

   localparam int NWIN     = 4;
   localparam int TIMEOUT  = 8;
   localparam int MAXSHEET = 5;

   // Expected done/abort response for one transaction
   typedef struct {
      int win;
      bit isDone;
      bit coreAbort;
      int chg;
      int sh;
   } resp_t;

   // Expected fields on a core start
   typedef struct {
      int s1;
      int s2;
      int sh;
   } start_t;

   // How the core stub answers a start (lat=0 means never)
   typedef struct {
      int lat;
      int chg;
      int sh;
   } stub_t;

   logic              clk;
   logic              reset;
   logic [NWIN-1:0]   win_req;
   logic [4*NWIN-1:0] win_station1;
   logic [4*NWIN-1:0] win_station2;
   logic [3*NWIN-1:0] win_sheet;
   logic [NWIN-1:0]   win_gnt;
   logic [NWIN-1:0]   win_done;
   logic [NWIN-1:0]   win_abort;
   logic [6:0]        out_change;
   logic [2:0]        out_sheet;
   logic              core_start;
   logic [3:0]        core_station1;
   logic [3:0]        core_station2;
   logic [2:0]        core_sheet;
   logic              core_abort;
   logic              core_done;
   logic [6:0]        core_change;
   logic [2:0]        core_sheet_out;

   resp_t           respQ[$];
   start_t          startQ[$];
   stub_t           stubQ[$];
   int              errors = 0;
   int              checks = 0;
   int              cyc = 0;
   int              startCyc = 0;
   logic [NWIN-1:0] rereq;

   seller_arbiter #(
      .NWIN    (NWIN),
      .TIMEOUT (TIMEOUT),
      .MAXSHEET(MAXSHEET)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .win_req       (win_req),
      .win_station1  (win_station1),
      .win_station2  (win_station2),
      .win_sheet     (win_sheet),
      .win_gnt       (win_gnt),
      .win_done      (win_done),
      .win_abort     (win_abort),
      .out_change    (out_change),
      .out_sheet     (out_sheet),
      .core_start    (core_start),
      .core_station1 (core_station1),
      .core_station2 (core_station2),
      .core_sheet    (core_sheet),
      .core_abort    (core_abort),
      .core_done     (core_done),
      .core_change   (core_change),
      .core_sheet_out(core_sheet_out)
   );

   // Free-running 100 MHz clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle counter used to measure the watchdog delay
   always @(posedge clk) begin
      cyc <= cyc + 1;
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // kind: 0 done, 1 rejected by validation, 2 watchdog timeout, 3 start only
   task automatic applyStimulus(input int w, input int s1, input int s2, input int sh, input int kind,
                                input int lat, input int chg, input int osh, input bit again);
      resp_t  r;
      start_t s;
      stub_t  b;
      if (again) begin
         rereq[w] = 1'b1;
      end else begin
         win_station1[w*4 +: 4] = 4'(s1);
         win_station2[w*4 +: 4] = 4'(s2);
         win_sheet[w*3 +: 3]    = 3'(sh);
         win_req[w]             = 1'b1;
      end
      if (kind != 1) begin
         s.s1 = s1; s.s2 = s2; s.sh = sh;
         startQ.push_back(s);
         b.lat = (kind == 0) ? lat : 0; b.chg = chg; b.sh = osh;
         stubQ.push_back(b);
      end
      if (kind != 3) begin
         r.win       = w;
         r.isDone    = (kind == 0);
         r.coreAbort = (kind == 2);
         r.chg       = (kind == 0) ? chg : 0;
         r.sh        = (kind == 0) ? osh : 0;
         respQ.push_back(r);
      end
   endtask

   // Run until every expected response has appeared, releasing served requests
   task automatic drain(input int budget);
      logic [NWIN-1:0] served;
      int n;
      n = 0;
      while (n < budget && (respQ.size() != 0 || win_req != '0)) begin
         @(negedge clk);
         n++;
         served = win_done | win_abort;
         if (served != '0) begin
            win_req = (win_req & ~served) | (served & rereq);
            rereq   = rereq & ~served;
         end
      end
      checkOutput("responses_pending", respQ.size(), 0);
      checkOutput("starts_pending", startQ.size(), 0);
      repeat (2) @(negedge clk);
   endtask

   task automatic flushAll();
      win_req = '0;
      rereq   = '0;
      respQ.delete();
      startQ.delete();
      stubQ.delete();
   endtask

   task automatic doReset();
      @(negedge clk);
      reset = 1'b0;
      flushAll();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_gnt"}, win_gnt, 0);
      checkOutput({tag, "_pulses"}, {win_done, win_abort, core_start, core_abort}, 0);
      checkOutput({tag, "_result"}, {out_change, out_sheet}, 0);
      checkOutput({tag, "_core_fields"}, {core_station1, core_station2, core_sheet}, 0);
   endtask

   // Scoreboard monitor: compares every start and every done/abort pulse
   always @(negedge clk) begin : monitor
      resp_t           e;
      start_t          s;
      logic [NWIN-1:0] oh;
      logic [NWIN-1:0] doneOh;
      logic [NWIN-1:0] abortOh;
      if ((win_done | win_abort) != '0) begin
         if (respQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_response: got done=%b abort=%b, expected none", win_done, win_abort);
         end else begin
            e          = respQ.pop_front();
            oh         = '0;
            oh[e.win]  = 1'b1;
            doneOh     = e.isDone ? oh : '0;
            abortOh    = e.isDone ? '0 : oh;
            checkOutput("route_gnt_done_abort", {win_gnt, win_done, win_abort}, {oh, doneOh, abortOh});
            checkOutput("coreabort_change_sheet", {core_abort, out_change, out_sheet},
                        {e.coreAbort, 7'(e.chg), 3'(e.sh)});
         end
      end
      if (core_start) begin
         startCyc = cyc;
         if (startQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_core_start: got start with %0d/%0d/%0d, expected none",
                     core_station1, core_station2, core_sheet);
         end else begin
            s = startQ.pop_front();
            checkOutput("core_start_fields", {core_station1, core_station2, core_sheet},
                        {4'(s.s1), 4'(s.s2), 3'(s.sh)});
         end
      end
      if (core_abort) begin
         checkOutput("watchdog_delay", cyc - startCyc, TIMEOUT + 1);
      end
   end

   // Core stub: answers each start after the queued latency, or never
   initial begin : coreStub
      stub_t b;
      core_done      = 1'b0;
      core_change    = '0;
      core_sheet_out = '0;
      forever begin
         @(negedge clk);
         if (core_start && reset && stubQ.size() != 0) begin
            b = stubQ.pop_front();
            if (b.lat > 0) begin
               repeat (b.lat) @(posedge clk);
               #1;
               core_done      = 1'b1;
               core_change    = 7'(b.chg);
               core_sheet_out = 3'(b.sh);
               @(posedge clk);
               #1;
               core_done      = 1'b0;
               core_change    = '0;
               core_sheet_out = '0;
            end
         end
      end
   end

   // Hard time limit so the run always terminates
   initial begin : watchdog
      #500000;
      errors++;
      $display("[TB] FAIL sim_time_limit: got no finish, expected finish");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "[TB] time limit");
   end

   // Directed test sequence
   initial begin : stimulus
      int n;
      reset        = 1'b1;
      win_req      = '0;
      rereq        = '0;
      win_station1 = '0;
      win_station2 = '0;
      win_sheet    = '0;
      #2;
      reset = 1'b0;
      #1;
      checkAllZero("reset");
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // Single request on window 1, fields changed after the accept
      $display("[TB] single request window 1");
      applyStimulus(1, 1, 3, 3, 0, 2, 5, 3, 1'b0);
      @(negedge clk);
      checkOutput("gnt_one_cycle_after_req", win_gnt, 4'b0010);
      checkOutput("no_start_in_check", core_start, 0);
      @(negedge clk);
      checkOutput("start_two_cycles_after_req", core_start, 1);
      win_station1[7:4] = 4'd0;
      win_sheet[5:3]    = 3'd7;
      drain(100);

      // All four from reset, window 0 re-requests immediately
      $display("[TB] four windows round robin");
      doReset();
      applyStimulus(0, 1, 2, 1, 0, 1, 17, 1, 1'b0);
      applyStimulus(1, 2, 5, 2, 0, 3, 42, 2, 1'b0);
      applyStimulus(2, 3, 3, 5, 0, 2, 29, 5, 1'b0);
      applyStimulus(3, 4, 9, 4, 0, 1, 76, 4, 1'b0);
      applyStimulus(0, 1, 2, 1, 0, 1, 100, 1, 1'b1);
      drain(300);

      // Invalid requests are rejected and the pointer still advances
      $display("[TB] invalid requests");
      applyStimulus(2, 1, 2, 0, 1, 0, 0, 0, 1'b0);
      applyStimulus(3, 4, 2, 1, 1, 0, 0, 0, 1'b0);
      drain(100);
      applyStimulus(0, 1, 2, 6, 1, 0, 0, 0, 1'b0);
      drain(100);
      applyStimulus(1, 2, 5, 2, 0, 2, 42, 2, 1'b0);
      applyStimulus(0, 1, 2, 1, 0, 2, 17, 1, 1'b0);
      drain(200);

      // Watchdog timeout, then the next requester is served
      $display("[TB] watchdog timeout");
      applyStimulus(2, 1, 2, 1, 2, 0, 0, 0, 1'b0);
      applyStimulus(3, 4, 9, 4, 0, 2, 76, 4, 1'b0);
      drain(200);

      // Completion on the very cycle the watchdog would fire
      $display("[TB] done on timeout cycle");
      applyStimulus(1, 2, 5, 2, 0, 8, 42, 2, 1'b0);
      drain(100);

      // Reset while waiting on the core
      $display("[TB] reset during wait");
      applyStimulus(3, 4, 9, 4, 3, 0, 0, 0, 1'b0);
      n = 0;
      while (!core_start && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput("start_seen_before_reset", core_start, 1);
      repeat (3) @(posedge clk);
      #2;
      checkOutput("gnt_before_reset", win_gnt, 4'b1000);
      reset = 1'b0;
      #1;
      checkAllZero("async_reset");
      flushAll();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      applyStimulus(1, 2, 5, 2, 0, 2, 42, 2, 1'b0);
      applyStimulus(3, 4, 9, 4, 0, 2, 76, 4, 1'b0);
      drain(200);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
